// File: rtl/bufgce_div_sync_pkg.sv
// bufgce_div_sync_pkg: state encoding, parameter limits and counter helpers
// shared by the divided-clock buffer sequencer.
`default_nettype none

package bufgce_div_sync_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILTER = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_RUN    = 3'd4
    } state_t;

    localparam int CNT_W           = $clog2(256);
    localparam int NUM_BUF_MIN     = 1;
    localparam int NUM_BUF_MAX     = 8;
    localparam int LOCK_FILTER_MIN = 1;
    localparam int LOCK_FILTER_MAX = 255;
    localparam int CLR_CYCLES_MIN  = 1;
    localparam int CLR_CYCLES_MAX  = 255;
    localparam int CE_DELAY_MIN    = 1;
    localparam int CE_DELAY_MAX    = 255;

    // A state lasting N cycles loads N-1 and leaves when the counter reads 0.
    function automatic logic [CNT_W-1:0] load_of(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bufgce_div_sync_sync_2ff.sv
// sync_2ff: two-flop synchronizer with asynchronous active-high clear,
// used for both the LOCKED input and the CLR_in release.
`default_nettype none

module sync_2ff
    import bufgce_div_sync_pkg::*;
(
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

`default_nettype wire

// File: rtl/bufgce_div_sync.sv
// bufgce_div_sync: sequences CLR/CE of a bank of divided-clock buffers so the
// divided clocks start phase-aligned once the source clock is locked.
`default_nettype none

module bufgce_div_sync
    import bufgce_div_sync_pkg::*;
#(
    parameter int NUM_BUF     = 2,
    parameter int LOCK_FILTER = 8,
    parameter int CLR_CYCLES  = 4,
    parameter int CE_DELAY    = 2
)(
    input  logic               I,
    input  logic               CLR_in,
    input  logic               LOCKED,
    input  logic               RESTART,
    output logic [NUM_BUF-1:0] CE_OUT,
    output logic [NUM_BUF-1:0] CLR_OUT,
    output logic               READY,
    output logic [2:0]         STATE
);

    if (NUM_BUF < NUM_BUF_MIN || NUM_BUF > NUM_BUF_MAX) begin : g_bad_num_buf
        $error("bufgce_div_sync: NUM_BUF out of range");
    end
    if (LOCK_FILTER < LOCK_FILTER_MIN || LOCK_FILTER > LOCK_FILTER_MAX) begin : g_bad_lock_filter
        $error("bufgce_div_sync: LOCK_FILTER out of range");
    end
    if (CLR_CYCLES < CLR_CYCLES_MIN || CLR_CYCLES > CLR_CYCLES_MAX) begin : g_bad_clr_cycles
        $error("bufgce_div_sync: CLR_CYCLES out of range");
    end
    if (CE_DELAY < CE_DELAY_MIN || CE_DELAY > CE_DELAY_MAX) begin : g_bad_ce_delay
        $error("bufgce_div_sync: CE_DELAY out of range");
    end

    localparam logic [CNT_W-1:0] FILTER_LOAD = load_of(LOCK_FILTER);
    localparam logic [CNT_W-1:0] CLEAR_LOAD  = load_of(CLR_CYCLES);
    localparam logic [CNT_W-1:0] WAIT_LOAD   = load_of(CE_DELAY);

    logic             run_en;
    logic             lock_s;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ce_nxt;
    logic             clr_nxt;

    // Holds the FSM in IDLE until the CLR_in release has been synchronized.
    sync_2ff u_rst_sync (
        .clk (I),
        .clr (CLR_in),
        .d   (1'b1),
        .q   (run_en)
    );

    sync_2ff u_lock_sync (
        .clk (I),
        .clr (CLR_in),
        .d   (LOCKED),
        .q   (lock_s)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (lock_s) begin
                    state_nxt = ST_FILTER;
                    cnt_nxt   = FILTER_LOAD;
                end
            end
            ST_FILTER: begin
                if (!lock_s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = CLEAR_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_CLEAR: begin
                if (!lock_s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == '0) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!lock_s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (RESTART) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = CLEAR_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else if (RESTART) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = CLEAR_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they flip on the same edge
    // as the state register; buffers stay cleared until the sequence proper.
    always_comb begin
        ce_nxt  = 1'b0;
        clr_nxt = 1'b0;
        case (state_nxt)
            ST_IDLE, ST_FILTER, ST_CLEAR: clr_nxt = 1'b1;
            ST_RUN:                       ce_nxt  = 1'b1;
            default: begin
                ce_nxt  = 1'b0;
                clr_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge I or posedge CLR_in) begin
        if (CLR_in) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            CE_OUT  <= '0;
            CLR_OUT <= '1;
            READY   <= 1'b0;
        end else if (run_en) begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            CE_OUT  <= {NUM_BUF{ce_nxt}};
            CLR_OUT <= {NUM_BUF{clr_nxt}};
            READY   <= ce_nxt;
        end
    end

    assign STATE = state;

endmodule

`default_nettype wire

// File: tb/tb_bufgce_div_sync.sv
// tb_bufgce_div_sync: directed and randomized checks of three sequencer
// configurations against a phase-offset reference model.
`default_nettype none

module tb_bufgce_div_sync;

    logic I = 1'b0;
    logic CLR_in;
    logic LOCKED;
    logic RESTART;

    logic [1:0] ce_a, clr_a;
    logic [0:0] ce_b, clr_b;
    logic [7:0] ce_c, clr_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic [2:0] st_a, st_b, st_c;

    bufgce_div_sync dut_a (
        .I(I), .CLR_in(CLR_in), .LOCKED(LOCKED), .RESTART(RESTART),
        .CE_OUT(ce_a), .CLR_OUT(clr_a), .READY(rdy_a), .STATE(st_a)
    );

    bufgce_div_sync #(.NUM_BUF(1), .LOCK_FILTER(3), .CLR_CYCLES(1), .CE_DELAY(1)) dut_b (
        .I(I), .CLR_in(CLR_in), .LOCKED(LOCKED), .RESTART(RESTART),
        .CE_OUT(ce_b), .CLR_OUT(clr_b), .READY(rdy_b), .STATE(st_b)
    );

    bufgce_div_sync #(.NUM_BUF(8), .LOCK_FILTER(1), .CLR_CYCLES(1), .CE_DELAY(1)) dut_c (
        .I(I), .CLR_in(CLR_in), .LOCKED(LOCKED), .RESTART(RESTART),
        .CE_OUT(ce_c), .CLR_OUT(clr_c), .READY(rdy_c), .STATE(st_c)
    );

    always #5 I = ~I;

    int checks = 0;
    int errors = 0;

    // 2'b11 all bits set, 2'b00 all clear, 2'b01 bits disagree
    function automatic logic [1:0] code(input logic [7:0] v, input int w);
        logic [7:0] m;
        m = 8'((1 << w) - 1);
        if ((v & m) == m) return 2'b11;
        if (v == 8'd0)    return 2'b00;
        return 2'b01;
    endfunction

    logic [2:0] act_st  [3];
    logic       act_rdy [3];
    logic [1:0] act_ce  [3];
    logic [1:0] act_clr [3];
    assign act_st[0]  = st_a;  assign act_st[1]  = st_b;  assign act_st[2]  = st_c;
    assign act_rdy[0] = rdy_a; assign act_rdy[1] = rdy_b; assign act_rdy[2] = rdy_c;
    assign act_ce[0]  = code(8'(ce_a), 2);  assign act_ce[1]  = code(8'(ce_b), 1);
    assign act_ce[2]  = code(ce_c, 8);
    assign act_clr[0] = code(8'(clr_a), 2); assign act_clr[1] = code(8'(clr_b), 1);
    assign act_clr[2] = code(clr_c, 8);

    // Reference model: el = cycles since the sequence entered FILTER (-1 = IDLE);
    // the phase follows from the per-configuration phase lengths.
    int   lf [3] = '{8, 3, 1};
    int   cc [3] = '{4, 1, 1};
    int   cd [3] = '{2, 1, 1};
    int   el [3];
    logic h1, h2;
    int   rel;

    function automatic int exp_state(input int k);
        if (el[k] < 0)                     return 0;
        if (el[k] < lf[k])                 return 1;
        if (el[k] < lf[k] + cc[k])         return 2;
        if (el[k] < lf[k] + cc[k] + cd[k]) return 3;
        return 4;
    endfunction

    task automatic model_edge(input logic lk, input logic rs);
        logic s;
        s = h2;  // LOCKED as sampled two edges ago
        if (rel >= 2) begin
            for (int k = 0; k < 3; k++) begin
                if (!s)                                el[k] = -1;
                else if (el[k] < 0)                    el[k] = 0;
                else if (rs && exp_state(k) >= 3)      el[k] = lf[k];
                else if (el[k] < lf[k] + cc[k] + cd[k]) el[k] = el[k] + 1;
            end
        end
        h2 = h1;
        h1 = lk;
        if (rel < 2) rel = rel + 1;
    endtask

    task automatic hit_reset;
        CLR_in = 1'b1;
        el     = '{-1, -1, -1};
        h1     = 1'b0;
        h2     = 1'b0;
        rel    = 0;
    endtask

    task automatic step(input logic lk, input logic rs);
        @(negedge I);
        LOCKED  = lk;
        RESTART = rs;
        CLR_in  = 1'b0;
        @(posedge I);
        model_edge(lk, rs);
        #1;
    endtask

    task automatic test_reset;
        LOCKED  = 1'b0;
        RESTART = 1'b0;
        hit_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (act_st[k] !== 3'd0 || act_ce[k] !== 2'b00 || act_clr[k] !== 2'b11 || act_rdy[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: state=%0d ce=%b clr=%b ready=%b want 0/00/11/0",
                         k, act_st[k], act_ce[k], act_clr[k], act_rdy[k]);
            end
        end
        for (int n = 1; n <= 2; n++) begin
            step(1'b1, 1'b0);
            checks++;
            if (st_a !== 3'd0) begin
                errors++;
                $display("FAIL reset_release_hold edge%0d: state=%0d want 0", n, st_a);
            end
        end
    endtask

    task automatic test_lock_seq;
        int fall_at, ce_at, rdy_at;
        fall_at = -1; ce_at = -1; rdy_at = -1;
        hit_reset();
        for (int n = 1; n <= 40; n++) begin
            step(n >= 10, 1'b0);
            if (fall_at < 0 && clr_a == 2'b00) fall_at = n;
            if (ce_at < 0 && ce_a == 2'b11)    ce_at = n;
            if (rdy_at < 0 && rdy_a)           rdy_at = n;
        end
        checks++;
        if (fall_at != 24) begin
            errors++;
            $display("FAIL lock_seq_clr_fall: edge=%0d want 24", fall_at);
        end
        checks++;
        if (ce_at != 26) begin
            errors++;
            $display("FAIL lock_seq_ce_rise: edge=%0d want 26", ce_at);
        end
        checks++;
        if (rdy_at != 26) begin
            errors++;
            $display("FAIL lock_seq_ready_rise: edge=%0d want 26", rdy_at);
        end
    endtask

    task automatic test_lock_glitch;
        int n, filt_cnt;
        logic saw_idle;
        hit_reset();
        n = 0;
        while (st_a != 3'd1 && n < 40) begin step(1'b1, 1'b0); n++; end
        checks++;
        if (st_a !== 3'd1) begin
            errors++;
            $display("FAIL glitch_reach_filter: state=%0d want 1", st_a);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        saw_idle = 1'b0;
        filt_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0);
            if (st_a == 3'd0) saw_idle = 1'b1;
            if (saw_idle && st_a == 3'd1) filt_cnt++;
            if (saw_idle && st_a == 3'd2) break;
        end
        checks++;
        if (saw_idle !== 1'b1) begin
            errors++;
            $display("FAIL glitch_to_idle: saw_idle=%b want 1", saw_idle);
        end
        checks++;
        if (filt_cnt != 8) begin
            errors++;
            $display("FAIL glitch_refilter_len: cycles=%0d want 8", filt_cnt);
        end
    endtask

    task automatic test_restart;
        int n, clr_cnt, fall_at, ce_at;
        n = 0;
        while (st_a != 3'd4 && n < 40) begin step(1'b1, 1'b0); n++; end
        checks++;
        if (st_a !== 3'd4) begin
            errors++;
            $display("FAIL restart_reach_run: state=%0d want 4", st_a);
        end
        step(1'b1, 1'b1);
        checks++;
        if (ce_a !== 2'b00 || rdy_a !== 1'b0 || st_a !== 3'd2 || clr_a !== 2'b11) begin
            errors++;
            $display("FAIL restart_immediate: ce=%b ready=%b state=%0d clr=%b want 00/0/2/11",
                     ce_a, rdy_a, st_a, clr_a);
        end
        clr_cnt = 1; fall_at = -1; ce_at = -1;
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0);
            if (fall_at < 0 && clr_a == 2'b11) clr_cnt++;
            if (fall_at < 0 && clr_a == 2'b00) fall_at = i;
            if (ce_at < 0 && ce_a == 2'b11)    ce_at = i;
        end
        checks++;
        if (clr_cnt != 4) begin
            errors++;
            $display("FAIL restart_clr_len: cycles=%0d want 4", clr_cnt);
        end
        checks++;
        if (fall_at < 0 || ce_at - fall_at != 2) begin
            errors++;
            $display("FAIL restart_ce_delay: gap=%0d want 2", ce_at - fall_at);
        end
    endtask

    task automatic test_lock_vs_restart;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (st_a !== 3'd4) begin
            errors++;
            $display("FAIL lockloss_sync_latency: state=%0d want 4", st_a);
        end
        step(1'b0, 1'b1);
        checks++;
        if (st_a !== 3'd0 || ce_a !== 2'b00 || clr_a !== 2'b11) begin
            errors++;
            $display("FAIL lockloss_over_restart: state=%0d ce=%b clr=%b want 0/00/11", st_a, ce_a, clr_a);
        end
    endtask

    task automatic test_clr_in_wait;
        int n;
        n = 0;
        while (st_a != 3'd3 && n < 40) begin step(1'b1, 1'b0); n++; end
        checks++;
        if (st_a !== 3'd3) begin
            errors++;
            $display("FAIL clrin_reach_wait: state=%0d want 3", st_a);
        end
        #2;
        hit_reset();
        #1;
        checks++;
        if (st_a !== 3'd0 || ce_a !== 2'b00 || clr_a !== 2'b11 || rdy_a !== 1'b0) begin
            errors++;
            $display("FAIL clrin_async_abort: state=%0d ce=%b clr=%b ready=%b want 0/00/11/0",
                     st_a, ce_a, clr_a, rdy_a);
        end
    endtask

    task automatic test_random;
        logic lk, rs;
        int   es;
        for (int n = 0; n < 800; n++) begin
            lk = ($urandom_range(0, 39) != 0);
            rs = ($urandom_range(0, 9) == 0);
            step(lk, rs);
            for (int k = 0; k < 3; k++) begin
                es = exp_state(k);
                checks++;
                if (act_st[k] !== 3'(es) || act_ce[k] !== (es == 4 ? 2'b11 : 2'b00) ||
                    act_clr[k] !== (es <= 2 ? 2'b11 : 2'b00) || act_rdy[k] !== (es == 4)) begin
                    errors++;
                    $display("FAIL random dut%0d cycle%0d: state=%0d ce=%b clr=%b ready=%b want state %0d",
                             k, n, act_st[k], act_ce[k], act_clr[k], act_rdy[k], es);
                end
            end
            checks++;
            if ((|(ce_a & clr_a)) || (|(ce_b & clr_b)) || (|(ce_c & clr_c))) begin
                errors++;
                $display("FAIL random_ce_clr_overlap cycle%0d: a=%b/%b b=%b/%b c=%b/%b want no overlap",
                         n, ce_a, clr_a, ce_b, clr_b, ce_c, clr_c);
            end
            if ($urandom_range(0, 149) == 0) hit_reset();
        end
    endtask

    initial begin
        test_reset();
        test_lock_seq();
        test_lock_glitch();
        test_restart();
        test_lock_vs_restart();
        test_clr_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
